// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard controller.
package hazard_pkg;

    localparam int LOAD_LAT_MAX = 4;
    // Entries store rd at this fixed width so one struct covers every REG_AW in use.
    localparam int REG_AW_MAX   = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
    } sb_entry_t;

    typedef struct packed {
        logic pcWrite;
        logic ifidWrite;
        logic idexBubble;
        logic ifidFlush;
        logic pipeHold;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE  = ctrl_t'(5'b11000);
    localparam ctrl_t CTRL_STALL = ctrl_t'(5'b00100);
    localparam ctrl_t CTRL_FLUSH = ctrl_t'(5'b11010);
    localparam ctrl_t CTRL_HOLD  = ctrl_t'(5'b00001);

endpackage

// File: rtl/load_scoreboard.sv
// Shift register of in-flight loads (entry 0 = EX) with a parallel source-hit compare.
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                advance,
    input  logic                pushValid,
    input  logic [REG_AW-1:0]   pushRd,
    input  logic [REG_AW-1:0]   srcRs,
    input  logic [REG_AW-1:0]   srcRt,
    input  logic                rsUsed,
    input  logic                rtUsed,
    output logic [LOAD_LAT-1:0] hitVec
);

    sb_entry_t sb [LOAD_LAT];

    logic [REG_AW_MAX-1:0] rsExt;
    logic [REG_AW_MAX-1:0] rtExt;
    logic [REG_AW_MAX-1:0] pushExt;

    assign rsExt   = REG_AW_MAX'(srcRs);
    assign rtExt   = REG_AW_MAX'(srcRt);
    assign pushExt = REG_AW_MAX'(pushRd);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < LOAD_LAT; k++) sb[k] <= '0;
        end else if (advance) begin
            for (int k = LOAD_LAT - 1; k > 0; k--) sb[k] <= sb[k-1];
            sb[0] <= '{valid: pushValid, rd: pushExt};
        end
    end

    always_comb begin
        hitVec = '0;
        for (int k = 0; k < LOAD_LAT; k++)
            hitVec[k] = sb[k].valid && (sb[k].rd != '0) &&
                        ((rsUsed && (sb[k].rd == rsExt)) ||
                         (rtUsed && (sb[k].rd == rtExt)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls vs. memory freezes vs. branch flushes.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic              id_memread_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              mem_busy_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              idex_bubble_o,
    output logic              ifid_flush_o,
    output logic              pipe_hold_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    if (LOAD_LAT < 1 || LOAD_LAT > LOAD_LAT_MAX || REG_AW > REG_AW_MAX) begin : gBadParam
        $error("hazard_ctrl: LOAD_LAT or REG_AW out of range");
    end

    logic [LOAD_LAT-1:0] hitVec;
    logic                luse;
    logic                pushValid;
    ctrl_t               ctrl;
    logic [CNT_W-1:0]    stallCnt;

    assign luse = |hitVec;
    // A stalled consumer becomes a bubble, so only a non-stalled load is recorded.
    assign pushValid = !luse && id_memread_i && (id_rd_i != '0);

    load_scoreboard #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) uScoreboard (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance   (!mem_busy_i),
        .pushValid (pushValid),
        .pushRd    (id_rd_i),
        .srcRs     (id_rs_i),
        .srcRt     (id_rt_i),
        .rsUsed    (id_rs_used_i),
        .rtUsed    (id_rt_used_i),
        .hitVec    (hitVec)
    );

    always_comb begin
        ctrl = CTRL_IDLE;
        if (!rst_i)              ctrl = CTRL_IDLE;
        else if (mem_busy_i)     ctrl = CTRL_HOLD;
        else if (luse)           ctrl = CTRL_STALL;
        else if (branch_taken_i) ctrl = CTRL_FLUSH;
    end

    assign pc_write_o    = ctrl.pcWrite;
    assign ifid_write_o  = ctrl.ifidWrite;
    assign idex_bubble_o = ctrl.idexBubble;
    assign ifid_flush_o  = ctrl.ifidFlush;
    assign pipe_hold_o   = ctrl.pipeHold;

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            stallCnt <= '0;
        else if (luse && !mem_busy_i && (stallCnt != {CNT_W{1'b1}}))
            stallCnt <= stallCnt + 1'b1;
    end

    assign stall_cycles_o = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: one LOAD_LAT=1 instance and one LOAD_LAT=3 / 3-bit-counter instance on shared inputs.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs = '0, rt = '0, rd = '0;
    logic       rsUsed = 1'b0, rtUsed = 1'b0, memRead = 1'b0;
    logic       busy = 1'b0, branch = 1'b0;

    logic        aPc, aIfid, aBub, aFlush, aHold;
    logic [31:0] aCnt;
    logic        bPc, bIfid, bBub, bFlush, bHold;
    logic [2:0]  bCnt;

    int nTests = 0;
    int nFail  = 0;

    localparam logic [4:0] IDLE  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] FLUSH = 5'b11010;
    localparam logic [4:0] HOLD  = 5'b00001;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dutA (
        .clk_i(clk), .rst_i(rst), .id_rs_i(rs), .id_rt_i(rt),
        .id_rs_used_i(rsUsed), .id_rt_used_i(rtUsed), .id_memread_i(memRead),
        .id_rd_i(rd), .mem_busy_i(busy), .branch_taken_i(branch),
        .pc_write_o(aPc), .ifid_write_o(aIfid), .idex_bubble_o(aBub),
        .ifid_flush_o(aFlush), .pipe_hold_o(aHold), .stall_cycles_o(aCnt)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(3)) dutB (
        .clk_i(clk), .rst_i(rst), .id_rs_i(rs), .id_rt_i(rt),
        .id_rs_used_i(rsUsed), .id_rt_used_i(rtUsed), .id_memread_i(memRead),
        .id_rd_i(rd), .mem_busy_i(busy), .branch_taken_i(branch),
        .pc_write_o(bPc), .ifid_write_o(bIfid), .idex_bubble_o(bBub),
        .ifid_flush_o(bFlush), .pipe_hold_o(bHold), .stall_cycles_o(bCnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one ID instruction for the coming cycle; outputs settle before the next rising edge.
    task automatic cyc(input logic [4:0] iRs, input logic iRsU, input logic [4:0] iRt,
                       input logic iRtU, input logic iMr, input logic [4:0] iRd,
                       input logic iBusy, input logic iBr);
        @(negedge clk);
        rs = iRs; rsUsed = iRsU; rt = iRt; rtUsed = iRtU;
        memRead = iMr; rd = iRd; busy = iBusy; branch = iBr;
        #1;
    endtask

    function automatic logic [4:0] ctlA();
        return {aPc, aIfid, aBub, aFlush, aHold};
    endfunction

    function automatic logic [4:0] ctlB();
        return {bPc, bIfid, bBub, bFlush, bHold};
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset: outputs idle even with busy and branch asserted
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("rst_ctlA", 32'(ctlA()), 32'(IDLE));
        chk("rst_ctlB", 32'(ctlB()), 32'(IDLE));
        chk("rst_cntA", aCnt, 0);
        chk("rst_cntB", 32'(bCnt), 0);
        rst = 1'b1;

        // LOAD_LAT=1: lw $8 ; add $x,$8 -> one bubble
        cyc(0, 0, 0, 0, 1, 8, 0, 0);
        chk("l1_lw_idle", 32'(ctlA()), 32'(IDLE));
        cyc(8, 1, 2, 1, 0, 0, 0, 0);
        chk("l1_stall", 32'(ctlA()), 32'(STALL));
        cyc(8, 1, 2, 1, 0, 0, 0, 0);
        chk("l1_resume", 32'(ctlA()), 32'(IDLE));
        chk("l1_cnt", aCnt, 1);

        // LOAD_LAT=3 back-to-back: 3 stalls
        doReset();
        cyc(0, 0, 0, 0, 1, 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(5, 1, 0, 0, 0, 0, 0, 0);
            chk("l3_stall", 32'(ctlB()), 32'(STALL));
            chk("l3_cnt", 32'(bCnt), 32'(i));
        end
        cyc(5, 1, 0, 0, 0, 0, 0, 0);
        chk("l3_resume", 32'(ctlB()), 32'(IDLE));
        chk("l3_cnt3", 32'(bCnt), 3);

        // One independent instruction in between: 2 stalls
        cyc(0, 0, 0, 0, 1, 5, 0, 0);
        cyc(1, 1, 2, 1, 0, 0, 0, 0);
        chk("gap_indep", 32'(ctlB()), 32'(IDLE));
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 5, 1, 0, 0, 0, 0);
            chk("gap_stall", 32'(ctlB()), 32'(STALL));
        end
        cyc(0, 0, 5, 1, 0, 0, 0, 0);
        chk("gap_resume", 32'(ctlB()), 32'(IDLE));
        chk("gap_cnt", 32'(bCnt), 5);

        // lw $0 and an unused rt match never stall
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        chk("r0_nostall", 32'(ctlB()), 32'(IDLE));
        cyc(0, 0, 0, 0, 1, 7, 0, 0);
        cyc(3, 1, 7, 0, 0, 0, 0, 0);
        chk("rtunused_nostall", 32'(ctlB()), 32'(IDLE));
        chk("nostall_cnt", 32'(bCnt), 5);

        // Busy during a stall freezes it; counter then saturates at 7
        cyc(0, 0, 0, 0, 1, 9, 0, 0);
        cyc(0, 0, 9, 1, 0, 0, 0, 0);
        chk("busy_pre_stall", 32'(ctlB()), 32'(STALL));
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 9, 1, 0, 0, 1, 0);
            chk("busy_hold", 32'(ctlB()), 32'(HOLD));
            chk("busy_cnt", 32'(bCnt), 6);
        end
        cyc(0, 0, 9, 1, 0, 0, 0, 0);
        chk("busy_post1", 32'(ctlB()), 32'(STALL));
        cyc(0, 0, 9, 1, 0, 0, 0, 0);
        chk("busy_post2", 32'(ctlB()), 32'(STALL));
        chk("sat_reach", 32'(bCnt), 7);
        cyc(0, 0, 9, 1, 0, 0, 0, 0);
        chk("busy_resume", 32'(ctlB()), 32'(IDLE));
        chk("sat_hold", 32'(bCnt), 7);

        // Stall suppresses the flush; flush appears once operands are ready
        cyc(0, 0, 0, 0, 1, 4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(4, 1, 0, 0, 0, 0, 0, 1);
            chk("br_stall", 32'(ctlB()), 32'(STALL));
        end
        cyc(4, 1, 0, 0, 0, 0, 0, 1);
        chk("br_flush", 32'(ctlB()), 32'(FLUSH));
        chk("br_sat", 32'(bCnt), 7);

        // Reset in the middle of a stall
        cyc(0, 0, 0, 0, 1, 6, 0, 0);
        cyc(6, 1, 0, 0, 0, 0, 0, 0);
        chk("mid_stall", 32'(ctlB()), 32'(STALL));
        rst = 1'b0;
        cyc(6, 1, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_idle", 32'(ctlB()), 32'(IDLE));
        rst = 1'b1;
        cyc(6, 1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_idle", 32'(ctlB()), 32'(IDLE));
        chk("post_rst_cntB", 32'(bCnt), 0);
        chk("post_rst_cntA", aCnt, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
